// File: rtl/pc_stack_pkg.sv
// Shared definitions for the program counter with return-address stack.
// Holds the operation encodings and operation width.
package pc_stack_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_INC    = 3'b000,
        OP_JUMP   = 3'b001,
        OP_BRANCH = 3'b010,
        OP_CALL   = 3'b011,
        OP_RET    = 3'b100,
        OP_HOLD   = 3'b101,
        OP_RSV6   = 3'b110,
        OP_RSV7   = 3'b111
    } op_e;

endpackage

// File: rtl/pc_stack_ras_lifo.sv
// Return-address stack: register-array LIFO, sync active-high reset of SP only.
// Ports: i_clk, i_rst, i_push, i_pop, i_data in; o_tos, o_empty, o_full out.
module pc_stack_ras_lifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_tos,
    output logic             o_empty,
    output logic             o_full
);

    localparam int SP_W  = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [SP_W-1:0]  r_sp;
    logic [SP_W-1:0]  w_sp_m1;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_empty   = (r_sp == '0);
    assign o_full    = (r_sp == SP_W'(DEPTH));
    assign w_sp_m1   = r_sp - SP_W'(1);
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    // Top of stack is garbage while empty; the caller never uses it then.
    assign o_tos = r_mem[w_sp_m1[IDX_W-1:0]];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sp <= '0;
        end else if (w_do_push) begin
            r_sp <= r_sp + SP_W'(1);
        end else if (w_do_pop) begin
            r_sp <= w_sp_m1;
        end
    end

    // Contents are never cleared; reset only empties the pointer.
    always_ff @(posedge i_clk) begin
        if (!i_rst && w_do_push) begin
            r_mem[r_sp[IDX_W-1:0]] <= i_data;
        end
    end

endmodule

// File: rtl/pc_stack.sv
// Fetch-stage PC: increment, jump, relative branch, call/return via RAS.
// Ports: i_clk, i_rst, i_en, i_op, i_address, i_offset in;
//        o_q, o_stack_empty, o_stack_full, o_err out.
module pc_stack
    import pc_stack_pkg::*;
#(
    parameter int             WIDTH     = 16,
    parameter int             OFF_W     = 8,
    parameter int             DEPTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic [OP_W-1:0]  i_op,
    input  logic [WIDTH-1:0] i_address,
    input  logic [OFF_W-1:0] i_offset,
    output logic [WIDTH-1:0] o_q,
    output logic             o_stack_empty,
    output logic             o_stack_full,
    output logic             o_err
);

    logic [WIDTH-1:0] r_q;
    logic             r_err;
    logic [WIDTH-1:0] w_q_next;
    logic [WIDTH-1:0] w_q_inc;
    logic [WIDTH-1:0] w_off_ext;
    logic [WIDTH-1:0] w_tos;
    logic             w_push;
    logic             w_pop;
    logic             w_err_set;
    logic             w_empty;
    logic             w_full;

    assign w_q_inc   = r_q + WIDTH'(1);
    assign w_off_ext = {{(WIDTH-OFF_W){i_offset[OFF_W-1]}}, i_offset};

    pc_stack_ras_lifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ras (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_q_inc),
        .o_tos   (w_tos),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    // Stack faults and reserved ops leave Q where it is and flag ERR.
    always_comb begin
        w_q_next  = r_q;
        w_push    = 1'b0;
        w_pop     = 1'b0;
        w_err_set = 1'b0;
        if (i_en) begin
            unique case (op_e'(i_op))
                OP_INC:    w_q_next = w_q_inc;
                OP_JUMP:   w_q_next = i_address;
                OP_BRANCH: w_q_next = r_q + w_off_ext;
                OP_CALL: begin
                    if (w_full) begin
                        w_err_set = 1'b1;
                    end else begin
                        w_push   = 1'b1;
                        w_q_next = i_address;
                    end
                end
                OP_RET: begin
                    if (w_empty) begin
                        w_err_set = 1'b1;
                    end else begin
                        w_pop    = 1'b1;
                        w_q_next = w_tos;
                    end
                end
                OP_HOLD:   w_q_next = r_q;
                default:   w_err_set = 1'b1;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q   <= RESET_VEC;
            r_err <= 1'b0;
        end else if (i_en) begin
            r_q   <= w_q_next;
            r_err <= r_err | w_err_set;
        end
    end

    assign o_q           = r_q;
    assign o_err         = r_err;
    assign o_stack_empty = w_empty;
    assign o_stack_full  = w_full;

endmodule

// File: tb/tb_pc_stack.sv
// Self-checking bench for pc_stack: vector table, call/return depth
// sequence, and randomized ops against a queue-based reference model.
module tb_pc_stack;

    localparam int WIDTH = 16;
    localparam int OFF_W = 8;
    localparam int DEPTH = 8;
    localparam logic [WIDTH-1:0] RV = 16'h0000;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [2:0]       op;
    logic [WIDTH-1:0] addr;
    logic [OFF_W-1:0] off;
    logic [WIDTH-1:0] q;
    logic             s_empty;
    logic             s_full;
    logic             err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pc_stack #(
        .WIDTH     (WIDTH),
        .OFF_W     (OFF_W),
        .DEPTH     (DEPTH),
        .RESET_VEC (RV)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_en          (en),
        .i_op          (op),
        .i_address     (addr),
        .i_offset      (off),
        .o_q           (q),
        .o_stack_empty (s_empty),
        .o_stack_full  (s_full),
        .o_err         (err)
    );

    typedef struct {
        logic             rst;
        logic             en;
        logic [2:0]       op;
        logic [WIDTH-1:0] addr;
        logic [OFF_W-1:0] off;
        logic [WIDTH-1:0] q;
        logic             e;
        logic             f;
        logic             err;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic r, input logic n, input logic [2:0] o,
                       input logic [15:0] a, input logic [7:0] b,
                       input logic [15:0] eq, input logic ee,
                       input logic ef, input logic er);
        vec_t v;
        v.rst = r; v.en = n; v.op = o; v.addr = a; v.off = b;
        v.q = eq; v.e = ee; v.f = ef; v.err = er;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Apply one cycle of inputs, then sample just after the edge.
    task automatic cyc(input logic r, input logic n, input logic [2:0] o,
                       input logic [15:0] a, input logic [7:0] b);
        @(negedge clk);
        rst = r; en = n; op = o; addr = a; off = b;
        @(posedge clk);
        #1;
    endtask

    // Reference model state
    logic [WIDTH-1:0] m_q;
    logic             m_err;
    logic [WIDTH-1:0] m_stk[$];

    task automatic model(input logic r, input logic n, input logic [2:0] o,
                         input logic [15:0] a, input logic [7:0] b);
        int d;
        if (r) begin
            m_q = RV;
            m_err = 1'b0;
            m_stk.delete();
        end else if (n) begin
            d = b[7] ? int'(b) - 256 : int'(b);
            case (o)
                3'd0: m_q = m_q + 16'd1;
                3'd1: m_q = a;
                3'd2: m_q = 16'((int'(m_q) + d + 65536) % 65536);
                3'd3: begin
                    if (m_stk.size() == DEPTH) m_err = 1'b1;
                    else begin
                        m_stk.push_back(m_q + 16'd1);
                        m_q = a;
                    end
                end
                3'd4: begin
                    if (m_stk.size() == 0) m_err = 1'b1;
                    else m_q = m_stk.pop_back();
                end
                3'd5: ;
                default: m_err = 1'b1;
            endcase
        end
    endtask

    logic [WIDTH-1:0] rets[DEPTH];
    logic [WIDTH-1:0] qsave;

    initial begin
        rst = 1'b1; en = 1'b0; op = 3'd0; addr = '0; off = '0;

        add(1,0,0,16'h0000,8'h00, 16'h0000,1,0,0);
        for (int i = 1; i <= 5; i++)
            add(0,1,0,16'h0000,8'h00, 16'(i),1,0,0);
        add(0,1,1,16'h0010,8'h00, 16'h0010,1,0,0);
        add(0,1,2,16'h0000,8'hFE, 16'h000E,1,0,0);
        add(0,1,2,16'h0000,8'h05, 16'h0013,1,0,0);
        add(0,1,1,16'hFFFF,8'h00, 16'hFFFF,1,0,0);
        add(0,1,0,16'h0000,8'h00, 16'h0000,1,0,0);
        add(0,1,2,16'h0000,8'hFF, 16'hFFFF,1,0,0);
        add(0,1,2,16'h0000,8'h02, 16'h0001,1,0,0);
        add(0,1,1,16'h0020,8'h00, 16'h0020,1,0,0);
        add(0,1,3,16'h0100,8'h00, 16'h0100,0,0,0);
        add(0,1,5,16'h0000,8'h00, 16'h0100,0,0,0);
        add(0,1,4,16'h0000,8'h00, 16'h0021,1,0,0);
        add(0,1,4,16'h0000,8'h00, 16'h0021,1,0,1);
        add(0,1,0,16'h0000,8'h00, 16'h0022,1,0,1);
        add(1,1,0,16'h0000,8'h00, 16'h0000,1,0,0);
        add(0,1,7,16'h0055,8'h00, 16'h0000,1,0,1);
        add(1,0,0,16'h0000,8'h00, 16'h0000,1,0,0);
        add(0,1,6,16'h0055,8'h00, 16'h0000,1,0,1);
        add(1,0,0,16'h0000,8'h00, 16'h0000,1,0,0);
        add(0,1,1,16'h0040,8'h00, 16'h0040,1,0,0);
        for (int i = 0; i < 3; i++)
            add(0,0,3,16'h0200,8'h00, 16'h0040,1,0,0);
        add(0,1,3,16'h0200,8'h00, 16'h0200,0,0,0);
        add(1,1,3,16'h0300,8'h00, 16'h0000,1,0,0);
        add(0,1,4,16'h0000,8'h00, 16'h0000,1,0,1);
        add(1,0,0,16'h0000,8'h00, 16'h0000,1,0,0);

        foreach (vecs[i]) begin
            cyc(vecs[i].rst, vecs[i].en, vecs[i].op,
                vecs[i].addr, vecs[i].off);
            chk($sformatf("vec%0d q", i), 32'(q), 32'(vecs[i].q));
            chk($sformatf("vec%0d empty", i), 32'(s_empty), 32'(vecs[i].e));
            chk($sformatf("vec%0d full", i), 32'(s_full), 32'(vecs[i].f));
            chk($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].err));
        end

        // Fill the stack, overflow once, then unwind it.
        cyc(1,0,0,16'h0,8'h0);
        cyc(0,1,1,16'h1000,8'h0);
        for (int i = 0; i < DEPTH; i++) begin
            rets[i] = (i == 0) ? 16'h1001 : 16'(16'h2000 + (i-1)*16 + 1);
            cyc(0,1,3,16'(16'h2000 + i*16),8'h0);
            chk("call q", 32'(q), 32'(16'h2000 + i*16));
            chk("call full", 32'(s_full), (i == DEPTH-1) ? 32'd1 : 32'd0);
        end
        qsave = 16'(16'h2000 + (DEPTH-1)*16);
        chk("call err before ovf", 32'(err), 32'd0);
        cyc(0,1,3,16'h3000,8'h0);
        chk("ovf q", 32'(q), 32'(qsave));
        chk("ovf err", 32'(err), 32'd1);
        chk("ovf full", 32'(s_full), 32'd1);
        for (int i = DEPTH-1; i >= 0; i--) begin
            cyc(0,1,4,16'h0,8'h0);
            chk("ret q", 32'(q), 32'(rets[i]));
        end
        chk("unwind empty", 32'(s_empty), 32'd1);
        chk("unwind full", 32'(s_full), 32'd0);

        // Randomized ops against the reference model.
        cyc(1,0,0,16'h0,8'h0);
        model(1,0,0,16'h0,8'h0);
        for (int i = 0; i < 3000; i++) begin
            logic r, n;
            logic [2:0] o;
            logic [15:0] a;
            logic [7:0] b;
            int sel;
            r = ($urandom_range(0,79) == 0);
            n = ($urandom_range(0,3) != 0);
            sel = $urandom_range(0,9);
            if (sel < 4) o = 3'd3;
            else if (sel < 7) o = 3'd4;
            else o = 3'($urandom_range(0,7));
            a = 16'($urandom);
            b = 8'($urandom);
            cyc(r,n,o,a,b);
            model(r,n,o,a,b);
            chk("rnd q", 32'(q), 32'(m_q));
            chk("rnd empty", 32'(s_empty), 32'(m_stk.size() == 0));
            chk("rnd full", 32'(s_full), 32'(m_stk.size() == DEPTH));
            chk("rnd err", 32'(err), 32'(m_err));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
